// File: rtl/sha256_w_sched_stream_if.sv
// Schedule-word stream bundle: block load request in, one 32-bit W[t] per accepted beat out.
interface sha256_w_sched_stream_if;
  logic         start;
  logic [511:0] block_in;
  logic         busy;
  logic         w_valid;
  logic         w_ready;
  logic [31:0]  w_out;
  logic [5:0]   w_idx;
  logic         done;

  modport master (
    output start, block_in, w_ready,
    input  busy, w_valid, w_out, w_idx, done
  );

  modport slave (
    input  start, block_in, w_ready,
    output busy, w_valid, w_out, w_idx, done
  );
endinterface

// File: rtl/sha256_w_sched_stream.sv
// SHA-256 message schedule streamer: 16-word sliding window, W[t] produced one word per accepted beat.
module sha256_w_sched_stream #(
  parameter int ROUNDS   = 64,
  parameter bit PAD_MODE = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  sha256_w_sched_stream_if.slave     bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_reg, state_next;
  logic [31:0] win_reg   [16];
  logic [31:0] win_next  [16];
  logic [31:0] load_word [16];
  logic [5:0]  cnt_reg, cnt_next;
  logic        done_reg;
  logic        load, beat, last_beat;
  logic [31:0] w_new;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  genvar gi;

  // Padded mode replaces W[8..15] with the fixed second-block padding of a 256-bit message.
  generate
    for (gi = 0; gi < 16; gi++) begin : g_load
      if (PAD_MODE && gi >= 8) begin : g_pad_word
        assign load_word[gi] = (gi == 8)  ? 32'h8000_0000 :
                               (gi == 15) ? 32'h0000_0100 : 32'h0000_0000;
      end else begin : g_blk_word
        assign load_word[gi] = bus.block_in[511-32*gi -: 32];
      end
    end
    if (PAD_MODE) begin : g_pad_tail
      logic pad_unused;
      assign pad_unused = ^bus.block_in[255:0];
    end
  endgenerate

  assign load      = (state_reg == IDLE) && bus.start;
  assign beat      = (state_reg == RUN) && bus.w_ready;
  assign last_beat = beat && (cnt_reg == 6'(ROUNDS - 1));

  // Next word uses only registered window taps, so w_ready never reaches w_out combinationally.
  assign w_new = sig1(win_reg[14]) + win_reg[9] + sig0(win_reg[1]) + win_reg[0];

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      win_next[i] = win_reg[i];
    end
    cnt_next = cnt_reg;
    if (load) begin
      for (int i = 0; i < 16; i++) begin
        win_next[i] = load_word[i];
      end
      cnt_next = 6'd0;
    end else if (beat) begin
      for (int i = 0; i < 15; i++) begin
        win_next[i] = win_reg[i+1];
      end
      win_next[15] = w_new;
      cnt_next     = cnt_reg + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        win_reg[i] <= '0;
      end
      cnt_reg  <= '0;
      done_reg <= 1'b0;
    end else begin
      win_reg  <= win_next;
      cnt_reg  <= cnt_next;
      done_reg <= last_beat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_beat) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy    = (state_reg == RUN);
    bus.w_valid = (state_reg == RUN);
    bus.w_out   = (state_reg == RUN) ? win_reg[0] : 32'h0;
    bus.w_idx   = (state_reg == RUN) ? cnt_reg : 6'd0;
    bus.done    = done_reg;
  end

endmodule
